// File: rtl/sysmem_frame_loader.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : sysmem_frame_loader
// Purpose  : Loads one image into system memory, then copies it word by word
//            into a double-banked frame buffer.
// Revision : 1.0 - initial release
// ============================================================================
module sysmem_frame_loader #(
    parameter int DEPTH     = 100,
    parameter int AW        = 7,
    parameter int DW        = 24,
    parameter int LOAD_WAIT = 2
) (
    input  logic          Clock,
    input  logic          Reset,
    input  logic          Start,
    input  logic          Abort,
    output logic          WESM,
    output logic          RESM,
    output logic [AW-1:0] AddrSM,
    input  logic [DW-1:0] WData,
    input  logic          FbReady,
    output logic          FbWe,
    output logic [AW-1:0] FbAddr,
    output logic [DW-1:0] FbData,
    output logic          FbBank,
    output logic          Busy,
    output logic          Done,
    output logic [1:0]    FrameCnt
);

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] LOAD  = 3'd1;
    localparam logic [2:0] WAIT  = 3'd2;
    localparam logic [2:0] READ  = 3'd3;
    localparam logic [2:0] CAPT  = 3'd4;
    localparam logic [2:0] WRITE = 3'd5;
    localparam logic [2:0] DONE  = 3'd6;

    localparam int            WCW       = (LOAD_WAIT > 1) ? $clog2(LOAD_WAIT) : 1;
    localparam logic [WCW-1:0] WAIT_LAST = WCW'(LOAD_WAIT - 1);
    localparam logic [AW-1:0]  IDX_LAST  = AW'(DEPTH - 1);

    logic [2:0]     state;
    logic [2:0]     state_next;
    logic [AW-1:0]  idx;
    logic [AW-1:0]  idx_next;
    logic [WCW-1:0] wait_cnt;
    logic [WCW-1:0] wait_next;
    logic           write_phase;

    always_comb begin
        state_next = state;
        idx_next   = idx;
        wait_next  = wait_cnt;
        case (state)
            IDLE: if (Start) state_next = LOAD;
            LOAD: begin
                state_next = WAIT;
                wait_next  = '0;
            end
            WAIT: begin
                if (wait_cnt == WAIT_LAST) begin
                    state_next = READ;
                    idx_next   = '0;
                    wait_next  = '0;
                end else begin
                    wait_next = wait_cnt + 1'b1;
                end
            end
            READ:  state_next = CAPT;
            CAPT:  state_next = WRITE;
            WRITE: begin
                if (FbReady) begin
                    if (idx == IDX_LAST) begin
                        state_next = DONE;
                    end else begin
                        idx_next   = idx + 1'b1;
                        state_next = READ;
                    end
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
        // Abort in IDLE is a no-op so a simultaneous Start still launches a frame.
        if (Abort && (state != IDLE)) begin
            state_next = IDLE;
            idx_next   = '0;
            wait_next  = '0;
        end
    end

    // Outputs are decoded from the next state so they line up with the state they describe.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state       <= IDLE;
            idx         <= '0;
            wait_cnt    <= '0;
            WESM        <= 1'b0;
            RESM        <= 1'b0;
            AddrSM      <= '0;
            FbAddr      <= '0;
            FbData      <= '0;
            FbBank      <= 1'b0;
            Busy        <= 1'b0;
            Done        <= 1'b0;
            FrameCnt    <= 2'd0;
            write_phase <= 1'b0;
        end else begin
            state       <= state_next;
            idx         <= idx_next;
            wait_cnt    <= wait_next;
            WESM        <= (state_next == LOAD);
            RESM        <= (state_next == READ) || (state_next == CAPT);
            Busy        <= (state_next != IDLE);
            Done        <= (state_next == DONE);
            write_phase <= (state_next == WRITE);
            if (state_next == READ) begin
                AddrSM <= idx_next;
            end
            if ((state == CAPT) && (state_next == WRITE)) begin
                FbData <= WData;
                FbAddr <= idx;
            end
            if ((state_next == DONE) && (state != DONE)) begin
                FbBank   <= ~FbBank;
                FrameCnt <= FrameCnt + 2'd1;
            end
        end
    end

    // The write strobe follows FbReady in the same cycle so a stall never drops a word.
    assign FbWe = write_phase & FbReady;

endmodule
`default_nettype wire

// File: tb/tb_sysmem_frame_loader.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_sysmem_frame_loader
// Purpose  : Directed self-checking bench for sysmem_frame_loader.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sysmem_frame_loader;

    localparam int DEPTH     = 100;
    localparam int AW        = 7;
    localparam int DW        = 24;
    localparam int LOAD_WAIT = 2;
    localparam int FRAME_CYC = 1 + LOAD_WAIT + 3 * DEPTH;

    logic          clk = 1'b0;
    logic          Reset;
    logic          Start;
    logic          Abort;
    logic          FbReady;
    logic [DW-1:0] WData = '0;
    logic          WESM;
    logic          RESM;
    logic [AW-1:0] AddrSM;
    logic          FbWe;
    logic [AW-1:0] FbAddr;
    logic [DW-1:0] FbData;
    logic          FbBank;
    logic          Busy;
    logic          Done;
    logic [1:0]    FrameCnt;

    int checks = 0;
    int errors = 0;

    sysmem_frame_loader #(
        .DEPTH(DEPTH), .AW(AW), .DW(DW), .LOAD_WAIT(LOAD_WAIT)
    ) dut (
        .Clock(clk), .Reset(Reset), .Start(Start), .Abort(Abort),
        .WESM(WESM), .RESM(RESM), .AddrSM(AddrSM), .WData(WData),
        .FbReady(FbReady), .FbWe(FbWe), .FbAddr(FbAddr), .FbData(FbData),
        .FbBank(FbBank), .Busy(Busy), .Done(Done), .FrameCnt(FrameCnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Image content depends on which load it is, so a stale image is visible.
    function automatic logic [DW-1:0] mem_word(input int im, input int a);
        return {im[7:0], a[7:0], im[7:0] + a[7:0] * 8'd3};
    endfunction

    function automatic logic [63:0] outs();
        return {18'd0, WESM, RESM, AddrSM, FbWe, FbAddr, FbData, FbBank, Busy, Done, FrameCnt};
    endfunction

    // System memory model: each WESM loads the next image, reads have one cycle latency.
    int img = 0;
    always @(posedge clk) begin
        if (WESM) img <= img + 1;
        if (RESM) WData <= mem_word(img, int'(AddrSM));
    end

    // Frame scoreboard
    int ncyc          = 0;
    int exp_addr      = 0;
    int wr_cnt        = 0;
    int wesm_in_frame = 0;
    int wesm_cyc      = 0;
    int done_total    = 0;
    int exp_latency   = FRAME_CYC;

    always @(negedge clk) begin
        ncyc++;
        if (!Reset) begin
            if (!Busy) wesm_in_frame = 0;
            if (WESM) begin
                wesm_in_frame++;
                wesm_cyc = ncyc;
                exp_addr = 0;
                wr_cnt   = 0;
            end
            if (RESM) check("rd_addr", AddrSM, exp_addr);
            if (FbWe) begin
                check("wr_addr", FbAddr, exp_addr);
                check("wr_data", FbData, mem_word(img, exp_addr));
                exp_addr++;
                wr_cnt++;
            end
            if (Done) begin
                done_total++;
                check("latency", ncyc - wesm_cyc, exp_latency);
                check("words", wr_cnt, DEPTH);
                check("wesm_per_frame", wesm_in_frame, 1);
            end
        end
    end

    task automatic start_pulse();
        @(negedge clk) Start = 1'b1;
        @(negedge clk) Start = 1'b0;
    endtask

    task automatic wait_done();
        bit found = 1'b0;
        for (int i = 0; i < 2000 && !found; i++) begin
            @(negedge clk);
            if (Done) found = 1'b1;
        end
        if (!found) check("done_timeout", 0, 1);
    endtask

    task automatic wait_rd(input int a);
        bit found = 1'b0;
        for (int i = 0; i < 2000 && !found; i++) begin
            @(negedge clk);
            if (RESM && (int'(AddrSM) == a)) found = 1'b1;
        end
        if (!found) check("rd_timeout", 0, 1);
    endtask

    initial begin
        int done_before;
        Reset   = 1'b1;
        Start   = 1'b1;
        Abort   = 1'b0;
        FbReady = 1'b1;

        // Reset with Start held
        repeat (3) @(negedge clk);
        check("rst_outputs", outs(), 64'd0);
        Reset = 1'b0;
        Start = 1'b0;
        @(negedge clk);
        check("idle_after_rst", outs(), 64'd0);

        // Full frame, FbReady always high
        exp_latency = FRAME_CYC;
        start_pulse();
        wait_done();
        @(negedge clk);
        check("f1_bank", FbBank, 1);
        check("f1_cnt", FrameCnt, 1);
        check("f1_idle", Busy, 0);

        // Stall at word 37
        exp_latency = FRAME_CYC + 5;
        start_pulse();
        wait_rd(37);
        FbReady = 1'b0;
        @(negedge clk);
        repeat (5) begin
            @(negedge clk);
            check("stall_we", FbWe, 0);
            check("stall_addr", FbAddr, 37);
            check("stall_data", FbData, mem_word(img, 37));
            check("stall_busy", Busy, 1);
        end
        @(posedge clk);
        #1 FbReady = 1'b1;
        wait_done();
        @(negedge clk);
        check("f2_bank", FbBank, 0);
        check("f2_cnt", FrameCnt, 2);

        // Abort at word 50, then a clean reload
        exp_latency = FRAME_CYC;
        start_pulse();
        wait_rd(50);
        Abort = 1'b1;
        done_before = done_total;
        @(negedge clk);
        check("abort_busy", Busy, 0);
        check("abort_resm", RESM, 0);
        check("abort_wesm", WESM, 0);
        check("abort_we", FbWe, 0);
        Abort = 1'b0;
        repeat (5) @(negedge clk);
        check("abort_nodone", done_total, done_before);
        check("abort_bank", FbBank, 0);
        check("abort_cnt", FrameCnt, 2);
        start_pulse();
        wait_done();
        @(negedge clk);
        check("f3_bank", FbBank, 1);
        check("f3_cnt", FrameCnt, 3);

        // Reset in READ of word 10, then a full frame
        start_pulse();
        wait_rd(10);
        Reset = 1'b1;
        @(negedge clk);
        check("midrst_outputs", outs(), 64'd0);
        Reset = 1'b0;
        start_pulse();
        wait_done();
        @(negedge clk);
        check("f4_bank", FbBank, 1);
        check("f4_cnt", FrameCnt, 1);

        // Back-to-back frames with Start held through Busy and DONE
        @(negedge clk) Start = 1'b1;
        for (int f = 0; f < 4; f++) begin
            wait_done();
            @(negedge clk);
            check("b2b_cnt", FrameCnt, (2 + f) % 4);
            check("b2b_bank", FbBank, f & 1);
            check("b2b_idle_wesm", WESM, 0);
            if (f == 3) begin
                Start = 1'b0;
            end else begin
                @(negedge clk);
                check("b2b_load_wesm", WESM, 1);
            end
        end
        repeat (3) @(negedge clk);
        check("final_idle", Busy, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

endmodule
`default_nettype wire
